matrix_slot_allocator: RTL and testbench



---
 rtl/matrix_slot_allocator.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_matrix_slot_allocator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_slot_allocator.sv
// matrix_slot_allocator: slot pool behind the UART matrix-input stage.
// Hands out a slot base for each (m,n) request, keeping at most MAX_PER_DIM
// matrices of any one shape. It resolves 1-based matrix IDs to slot
// information and owns the slot-organised element RAM.
// Optional build macro MATRIX_SLOT_CLEAR_EN adds a clear_req input. A pulse
// on clear_req in IDLE wipes every slot in one cycle.
module matrix_slot_allocator #(
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_WORDS  = 25,
    parameter int MAX_PER_DIM = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    input  logic [2:0]        alloc_m,
    input  logic [2:0]        alloc_n,
    output logic              alloc_ready,
    output logic [ADDR_W-1:0] alloc_base,
    output logic              alloc_evict,
    input  logic              lk_req,
    input  logic [31:0]       lk_id,
    output logic              lk_done,
    output logic              lk_hit,
    output logic [ADDR_W-1:0] lk_base,
    output logic [2:0]        lk_m,
    output logic [2:0]        lk_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_oob,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
`ifdef MATRIX_SLOT_CLEAR_EN
    input  logic              clear_req,
`endif
    output logic [3:0]        valid_count
);

    localparam int DEPTH = NUM_SLOTS * SLOT_WORDS;
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    typedef enum logic [2:0] {IDLE, ASCAN, ADONE, ACOOL, LSCAN, LDONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [2:0]        req_m_q, req_m_d, req_n_q, req_n_d;
    logic [31:0]       lk_id_q, lk_id_d;
    logic              lk_pend_q, lk_pend_d;

    logic              slot_valid_q [NUM_SLOTS];
    logic              slot_valid_d [NUM_SLOTS];
    logic [2:0]        slot_m_q [NUM_SLOTS];
    logic [2:0]        slot_m_d [NUM_SLOTS];
    logic [2:0]        slot_n_q [NUM_SLOTS];
    logic [2:0]        slot_n_d [NUM_SLOTS];
    logic [7:0]        slot_age_q [NUM_SLOTS];
    logic [7:0]        slot_age_d [NUM_SLOTS];

    logic              free_found_q, free_found_d;
    logic [IDX_W-1:0]  free_idx_q, free_idx_d;
    logic [CNT_W-1:0]  same_cnt_q, same_cnt_d;
    logic              same_found_q, same_found_d;
    logic [IDX_W-1:0]  same_idx_q, same_idx_d;
    logic [7:0]        same_age_q, same_age_d;
    logic              old_found_q, old_found_d;
    logic [IDX_W-1:0]  old_idx_q, old_idx_d;
    logic [7:0]        old_age_q, old_age_d;
    logic [IDX_W-1:0]  victim_q, victim_d;
    logic              victim_valid_q, victim_valid_d;
    logic [IDX_W-1:0]  vic;

    logic [CNT_W-1:0]  lk_cnt_q, lk_cnt_d;
    logic              lk_found_q, lk_found_d;
    logic [IDX_W-1:0]  lk_idx_q, lk_idx_d;

    logic              alloc_ready_q, alloc_ready_d, alloc_evict_q, alloc_evict_d;
    logic [ADDR_W-1:0] alloc_base_q, alloc_base_d;
    logic              lk_done_q, lk_done_d, lk_hit_q, lk_hit_d;
    logic [ADDR_W-1:0] lk_base_q, lk_base_d;
    logic [2:0]        lk_m_q, lk_m_d, lk_n_q, lk_n_d;
    logic [3:0]        count_q, count_d;

    logic [DATA_W-1:0] ram [DEPTH];
    logic              wr_in_range, rd_in_range;
    logic              wr_oob_q, wr_oob_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    function automatic logic [ADDR_W-1:0] slot_base(input logic [IDX_W-1:0] idx);
        return ADDR_W'(32'(idx) * SLOT_WORDS);
    endfunction

    // Next-state logic for the scan FSM, slot table and registered outputs
    always_comb begin
        state_d = state_q;  idx_d = idx_q;  req_m_d = req_m_q;  req_n_d = req_n_q;
        lk_id_d = lk_id_q;  lk_pend_d = lk_pend_q;
        slot_valid_d = slot_valid_q;  slot_m_d = slot_m_q;
        slot_n_d = slot_n_q;  slot_age_d = slot_age_q;
        free_found_d = free_found_q;  free_idx_d = free_idx_q;
        same_cnt_d = same_cnt_q;  same_found_d = same_found_q;
        same_idx_d = same_idx_q;  same_age_d = same_age_q;
        old_found_d = old_found_q;  old_idx_d = old_idx_q;  old_age_d = old_age_q;
        victim_d = victim_q;  victim_valid_d = victim_valid_q;  vic = '0;
        lk_cnt_d = lk_cnt_q;  lk_found_d = lk_found_q;  lk_idx_d = lk_idx_q;
        alloc_ready_d = 1'b0;  alloc_evict_d = 1'b0;  alloc_base_d = alloc_base_q;
        lk_done_d = 1'b0;  lk_hit_d = 1'b0;
        lk_base_d = lk_base_q;  lk_m_d = lk_m_q;  lk_n_d = lk_n_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
`ifdef MATRIX_SLOT_CLEAR_EN
                if (clear_req) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        slot_valid_d[i] = 1'b0;
                        slot_age_d[i]   = 8'd0;
                    end
                    count_d = 4'd0;
                    if (lk_req) begin
                        lk_pend_d = 1'b1;
                        lk_id_d   = lk_id;
                    end
                end else
`endif
                if (lk_req || lk_pend_q) begin
                    state_d    = LSCAN;
                    idx_d      = '0;
                    lk_pend_d  = 1'b0;
                    if (!lk_pend_q) lk_id_d = lk_id;
                    lk_cnt_d   = '0;
                    lk_found_d = 1'b0;
                    lk_idx_d   = '0;
                end else if (alloc_req) begin
                    state_d      = ASCAN;
                    idx_d        = '0;
                    req_m_d      = alloc_m;
                    req_n_d      = alloc_n;
                    free_found_d = 1'b0;  free_idx_d = '0;
                    same_cnt_d   = '0;    same_found_d = 1'b0;
                    same_idx_d   = '0;    same_age_d = 8'd0;
                    old_found_d  = 1'b0;  old_idx_d = '0;  old_age_d = 8'd0;
                end
            end
            ASCAN: begin
                if (!slot_valid_q[idx_q]) begin
                    if (!free_found_q) begin
                        free_found_d = 1'b1;
                        free_idx_d   = idx_q;
                    end
                end else begin
                    if (slot_m_q[idx_q] == req_m_q && slot_n_q[idx_q] == req_n_q) begin
                        same_cnt_d = same_cnt_q + 1'b1;
                        if (!same_found_q || slot_age_q[idx_q] > same_age_q) begin
                            same_found_d = 1'b1;
                            same_idx_d   = idx_q;
                            same_age_d   = slot_age_q[idx_q];
                        end
                    end
                    if (!old_found_q || slot_age_q[idx_q] > old_age_q) begin
                        old_found_d = 1'b1;
                        old_idx_d   = idx_q;
                        old_age_d   = slot_age_q[idx_q];
                    end
                end
                if (idx_q == LAST_IDX) begin
                    if (32'(same_cnt_d) >= MAX_PER_DIM) vic = same_idx_d;
                    else if (free_found_d)             vic = free_idx_d;
                    else                               vic = old_idx_d;
                    victim_d       = vic;
                    victim_valid_d = slot_valid_q[vic];
                    alloc_ready_d  = 1'b1;
                    alloc_evict_d  = slot_valid_q[vic];
                    alloc_base_d   = slot_base(vic);
                    state_d        = ADONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ADONE: begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (IDX_W'(i) == victim_q) begin
                        slot_valid_d[i] = 1'b1;
                        slot_age_d[i]   = 8'd0;
                        slot_m_d[i]     = req_m_q;
                        slot_n_d[i]     = req_n_q;
                    end else if (slot_valid_q[i] && slot_age_q[i] != 8'hFF) begin
                        slot_age_d[i] = slot_age_q[i] + 8'd1;
                    end
                end
                if (!victim_valid_q) count_d = count_q + 4'd1;
                state_d = ACOOL;
            end
            LSCAN: begin
                if (slot_valid_q[idx_q]) begin
                    lk_cnt_d = lk_cnt_q + 1'b1;
                    if (32'(lk_cnt_d) == lk_id_q) begin
                        lk_found_d = 1'b1;
                        lk_idx_d   = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    lk_done_d = 1'b1;
                    lk_hit_d  = lk_found_d;
                    lk_base_d = lk_found_d ? slot_base(lk_idx_d) : '0;
                    lk_m_d    = lk_found_d ? slot_m_q[lk_idx_d] : 3'd0;
                    lk_n_d    = lk_found_d ? slot_n_q[lk_idx_d] : 3'd0;
                    state_d   = LDONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ACOOL, LDONE: state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Control and slot-table registers; the RAM array itself is never reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;  idx_q <= '0;  req_m_q <= 3'd0;  req_n_q <= 3'd0;
            lk_id_q <= 32'd0;  lk_pend_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_valid_q[i] <= 1'b0;  slot_m_q[i] <= 3'd0;
                slot_n_q[i] <= 3'd0;      slot_age_q[i] <= 8'd0;
            end
            free_found_q <= 1'b0;  free_idx_q <= '0;  same_cnt_q <= '0;
            same_found_q <= 1'b0;  same_idx_q <= '0;  same_age_q <= 8'd0;
            old_found_q <= 1'b0;   old_idx_q <= '0;   old_age_q <= 8'd0;
            victim_q <= '0;  victim_valid_q <= 1'b0;
            lk_cnt_q <= '0;  lk_found_q <= 1'b0;  lk_idx_q <= '0;
            alloc_ready_q <= 1'b0;  alloc_evict_q <= 1'b0;  alloc_base_q <= '0;
            lk_done_q <= 1'b0;  lk_hit_q <= 1'b0;  lk_base_q <= '0;
            lk_m_q <= 3'd0;  lk_n_q <= 3'd0;  count_q <= 4'd0;
        end else begin
            state_q <= state_d;  idx_q <= idx_d;  req_m_q <= req_m_d;  req_n_q <= req_n_d;
            lk_id_q <= lk_id_d;  lk_pend_q <= lk_pend_d;
            slot_valid_q <= slot_valid_d;  slot_m_q <= slot_m_d;
            slot_n_q <= slot_n_d;          slot_age_q <= slot_age_d;
            free_found_q <= free_found_d;  free_idx_q <= free_idx_d;  same_cnt_q <= same_cnt_d;
            same_found_q <= same_found_d;  same_idx_q <= same_idx_d;  same_age_q <= same_age_d;
            old_found_q <= old_found_d;    old_idx_q <= old_idx_d;    old_age_q <= old_age_d;
            victim_q <= victim_d;  victim_valid_q <= victim_valid_d;
            lk_cnt_q <= lk_cnt_d;  lk_found_q <= lk_found_d;  lk_idx_q <= lk_idx_d;
            alloc_ready_q <= alloc_ready_d;  alloc_evict_q <= alloc_evict_d;
            alloc_base_q <= alloc_base_d;
            lk_done_q <= lk_done_d;  lk_hit_q <= lk_hit_d;  lk_base_q <= lk_base_d;
            lk_m_q <= lk_m_d;  lk_n_q <= lk_n_d;  count_q <= count_d;
        end
    end

    // Address range decode and next values for the read/oob registers
    always_comb begin
        wr_in_range = (32'(wr_addr) < DEPTH);
        rd_in_range = (32'(rd_addr) < DEPTH);
        wr_oob_d    = wr_en && !wr_in_range;
        rd_data_d   = rd_in_range ? ram[rd_addr] : '0;
    end

    // Element RAM write port, live in every FSM state
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) ram[wr_addr] <= wr_data;
    end

    // Registered read data (old data on same-address collision) and oob pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_oob_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_oob_q  <= wr_oob_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign alloc_ready = alloc_ready_q;
    assign alloc_base  = alloc_base_q;
    assign alloc_evict = alloc_evict_q;
    assign lk_done     = lk_done_q;
    assign lk_hit      = lk_hit_q;
    assign lk_base     = lk_base_q;
    assign lk_m        = lk_m_q;
    assign lk_n        = lk_n_q;
    assign wr_oob      = wr_oob_q;
    assign rd_data     = rd_data_q;
    assign valid_count = count_q;

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Directed bench for matrix_slot_allocator. Inputs are driven on the falling
// edge, and outputs are sampled on the falling edge.
module tb_matrix_slot_allocator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_req = 1'b0;
    logic [2:0]  alloc_m = 3'd0;
    logic [2:0]  alloc_n = 3'd0;
    logic        alloc_ready;
    logic [7:0]  alloc_base;
    logic        alloc_evict;
    logic        lk_req = 1'b0;
    logic [31:0] lk_id = 32'd0;
    logic        lk_done;
    logic        lk_hit;
    logic [7:0]  lk_base;
    logic [2:0]  lk_m;
    logic [2:0]  lk_n;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = 8'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_oob;
    logic [7:0]  rd_addr = 8'd0;
    logic [31:0] rd_data;
    logic [3:0]  valid_count;
`ifdef MATRIX_SLOT_CLEAR_EN
    logic        clear_req = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    int         lat;
    logic [7:0] base;
    logic       ev;
    logic       hit;
    logic [2:0] om;
    logic [2:0] on;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    matrix_slot_allocator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_m     (alloc_m),
        .alloc_n     (alloc_n),
        .alloc_ready (alloc_ready),
        .alloc_base  (alloc_base),
        .alloc_evict (alloc_evict),
        .lk_req      (lk_req),
        .lk_id       (lk_id),
        .lk_done     (lk_done),
        .lk_hit      (lk_hit),
        .lk_base     (lk_base),
        .lk_m        (lk_m),
        .lk_n        (lk_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_oob      (wr_oob),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
`ifdef MATRIX_SLOT_CLEAR_EN
        .clear_req   (clear_req),
`endif
        .valid_count (valid_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        alloc_req = 1'b0;
        lk_req = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Holds alloc_req until alloc_ready, then waits until the FSM is idle again
    task automatic applyAlloc(input logic [2:0] m, input logic [2:0] n, output int l,
                              output logic [7:0] b, output logic e);
        alloc_m = m;
        alloc_n = n;
        alloc_req = 1'b1;
        l = 0;
        b = 8'hFF;
        e = 1'bx;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (alloc_ready) begin
                l = cyc;
                b = alloc_base;
                e = alloc_evict;
                break;
            end
        end
        alloc_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Pulses lk_req for one cycle and captures the lk_done result
    task automatic applyLookup(input logic [31:0] id, output int l, output logic h,
                               output logic [7:0] b, output logic [2:0] m,
                               output logic [2:0] n);
        lk_id = id;
        lk_req = 1'b1;
        l = 0;
        h = 1'bx;
        b = 8'hFF;
        m = 3'd7;
        n = 3'd7;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            lk_req = 1'b0;
            if (lk_done) begin
                l = cyc;
                h = lk_hit;
                b = lk_base;
                m = lk_m;
                n = lk_n;
                break;
            end
        end
        lk_req = 1'b0;
        @(negedge clk);
        checkOutput("lk_done_one_cycle", 32'(lk_done), 0);
    endtask

    // Directed test sequence
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_alloc_ready", 32'(alloc_ready), 0);
        checkOutput("rst_alloc_base", 32'(alloc_base), 0);
        checkOutput("rst_lk_done", 32'(lk_done), 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_valid_count", 32'(valid_count), 0);
        checkOutput("rst_wr_oob", 32'(wr_oob), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First allocation, 2x3
        $display("[TB] single allocation");
        applyAlloc(3'd2, 3'd3, lat, base, ev);
        checkOutput("a1_latency", 32'(lat), 9);
        checkOutput("a1_base", 32'(base), 0);
        checkOutput("a1_evict", 32'(ev), 0);
        checkOutput("a1_valid_count", 32'(valid_count), 1);

        // Same shape three times: third reuses the oldest 2x2
        $display("[TB] per-shape capacity");
        applyReset();
        applyAlloc(3'd2, 3'd2, lat, base, ev);
        checkOutput("s1_base", 32'(base), 0);
        checkOutput("s1_evict", 32'(ev), 0);
        applyAlloc(3'd2, 3'd2, lat, base, ev);
        checkOutput("s2_base", 32'(base), 25);
        checkOutput("s2_evict", 32'(ev), 0);
        applyAlloc(3'd2, 3'd2, lat, base, ev);
        checkOutput("s3_base", 32'(base), 0);
        checkOutput("s3_evict", 32'(ev), 1);
        checkOutput("s3_valid_count", 32'(valid_count), 2);

        // Fill all slots with distinct shapes, then one more new shape
        $display("[TB] full pool");
        applyReset();
        applyAlloc(3'd1, 3'd1, lat, base, ev);
        checkOutput("f0_base", 32'(base), 0);
        applyAlloc(3'd1, 3'd2, lat, base, ev);
        checkOutput("f1_base", 32'(base), 25);
        applyAlloc(3'd1, 3'd3, lat, base, ev);
        applyAlloc(3'd1, 3'd4, lat, base, ev);
        applyAlloc(3'd1, 3'd5, lat, base, ev);
        applyAlloc(3'd2, 3'd1, lat, base, ev);
        applyAlloc(3'd2, 3'd2, lat, base, ev);
        applyAlloc(3'd2, 3'd3, lat, base, ev);
        checkOutput("f7_base", 32'(base), 175);
        checkOutput("f7_evict", 32'(ev), 0);
        checkOutput("f7_valid_count", 32'(valid_count), 8);
        applyAlloc(3'd3, 3'd3, lat, base, ev);
        checkOutput("f8_base", 32'(base), 0);
        checkOutput("f8_evict", 32'(ev), 1);
        checkOutput("f8_valid_count", 32'(valid_count), 8);

        // Lookup by ordinal
        $display("[TB] lookup");
        applyReset();
        applyAlloc(3'd3, 3'd3, lat, base, ev);
        applyAlloc(3'd1, 3'd5, lat, base, ev);
        checkOutput("l_alloc_base", 32'(base), 25);
        applyLookup(32'd2, lat, hit, base, om, on);
        checkOutput("l2_latency", 32'(lat), 9);
        checkOutput("l2_hit", 32'(hit), 1);
        checkOutput("l2_base", 32'(base), 25);
        checkOutput("l2_m", 32'(om), 1);
        checkOutput("l2_n", 32'(on), 5);
        applyLookup(32'd1, lat, hit, base, om, on);
        checkOutput("l1_hit", 32'(hit), 1);
        checkOutput("l1_m", 32'(om), 3);
        applyLookup(32'd3, lat, hit, base, om, on);
        checkOutput("l3_hit", 32'(hit), 0);
        checkOutput("l3_base", 32'(base), 0);
        applyLookup(32'd0, lat, hit, base, om, on);
        checkOutput("l0_hit", 32'(hit), 0);
        checkOutput("l0_m", 32'(om), 0);

        // Element write/read port
        $display("[TB] RAM port");
        wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'd9;
        @(negedge clk);
        checkOutput("w7_oob", 32'(wr_oob), 0);
        wr_en = 1'b0; rd_addr = 8'd7;
        @(negedge clk);
        checkOutput("r7_data", rd_data, 9);
        wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'd5;
        @(negedge clk);
        checkOutput("r7_old_data", rd_data, 9);
        wr_en = 1'b0;
        @(negedge clk);
        checkOutput("r7_new_data", rd_data, 5);
        wr_en = 1'b1; wr_addr = 8'd200; wr_data = 32'hDEAD;
        @(negedge clk);
        checkOutput("oob_pulse", 32'(wr_oob), 1);
        wr_en = 1'b0;
        @(negedge clk);
        checkOutput("oob_cleared", 32'(wr_oob), 0);
        checkOutput("oob_no_corrupt", rd_data, 5);

        // Reset in the middle of an allocation scan
        $display("[TB] reset mid-scan");
        applyReset();
        applyAlloc(3'd1, 3'd1, lat, base, ev);
        checkOutput("m_pre_count", 32'(valid_count), 1);
        alloc_m = 3'd2; alloc_n = 3'd2; alloc_req = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("m_rst_ready", 32'(alloc_ready), 0);
        checkOutput("m_rst_count", 32'(valid_count), 0);
        alloc_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("m_rst_hold_ready", 32'(alloc_ready), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        applyAlloc(3'd4, 3'd4, lat, base, ev);
        checkOutput("m_fresh_latency", 32'(lat), 9);
        checkOutput("m_fresh_base", 32'(base), 0);
        checkOutput("m_fresh_evict", 32'(ev), 0);
        checkOutput("m_fresh_count", 32'(valid_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
